// File: rtl/brick_render_pipe.sv
// brick_render_pipe: 3-stage pixel compositor (ball, paddles, brick field, hit flash).
module brick_render_pipe #(
  parameter int COLS         = 8,
  parameter int ROWS         = 8,
  parameter int BRICK_W      = 100,
  parameter int BRICK_H      = 50,
  parameter int GAP          = 5,
  parameter int FIELD_H      = 400,
  parameter int PADDLE_HALF  = 80,
  parameter int BALL_R       = 4,
  parameter int PL_Y0        = 20,
  parameter int PL_Y1        = 30,
  parameter int PR_Y0        = 570,
  parameter int PR_Y1        = 580,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [10:0]              x,
  input  logic [9:0]               y,
  input  logic                     active,
  input  logic                     hs_in,
  input  logic                     vs_in,
  input  logic                     frame_start,
  input  logic [10:0]              x_paddle_l,
  input  logic [10:0]              x_paddle_r,
  input  logic [10:0]              x_ball,
  input  logic [9:0]               y_ball,
  input  logic [2*COLS*ROWS-1:0]   bricks,
  input  logic                     hit_valid,
  input  logic [7:0]               hit_id,
  output logic [8:0]               rgb,
  output logic                     hs_out,
  output logic                     vs_out,
  output logic                     active_out
);

  localparam int N = COLS * ROWS;

  localparam logic [10:0] BW_X    = 11'(BRICK_W);
  localparam logic [9:0]  BH_Y    = 10'(BRICK_H);
  localparam logic [10:0] COLS_X  = 11'(COLS);
  localparam logic [9:0]  ROWS_Y  = 10'(ROWS);
  localparam logic [9:0]  FH_Y    = 10'(FIELD_H);
  localparam logic [10:0] GAP_X   = 11'(GAP);
  localparam logic [9:0]  GAP_Y   = 10'(GAP);
  localparam logic [10:0] XIN_HI  = 11'(BRICK_W - GAP);
  localparam logic [9:0]  YIN_HI  = 10'(BRICK_H - GAP);
  localparam logic [11:0] PH      = 12'(PADDLE_HALF);
  localparam logic [11:0] BR      = 12'(BALL_R);
  localparam logic [12:0] BSUM    = 13'(BALL_R + BALL_R / 4);
  localparam logic [9:0]  PL0     = 10'(PL_Y0);
  localparam logic [9:0]  PL1     = 10'(PL_Y1);
  localparam logic [9:0]  PR0     = 10'(PR_Y0);
  localparam logic [9:0]  PR1     = 10'(PR_Y1);
  localparam logic [7:0]  FLASH_N = 8'(FLASH_FRAMES);
  localparam logic [8:0]  N_IDS   = 9'(N);

  // frame-latched object positions
  logic [10:0] xl_sh, xr_sh, xb_sh;
  logic [9:0]  yb_sh;
  logic        armed;

  logic [7:0]  flash_id;
  logic [7:0]  flash_cnt;
  logic        hit_in_range;

  // stage 1
  logic               s1_active, s1_hs, s1_vs;
  logic [9:0]         s1_y;
  logic [10:0]        s1_bx, s1_ox;
  logic [9:0]         s1_by, s1_oy;
  logic signed [11:0] s1_dxl, s1_dxr, s1_dxb, s1_dyb;

  // stage 2
  logic       s2_active, s2_hs, s2_vs;
  logic       s2_in_brick, s2_flash, s2_pad_l, s2_pad_r, s2_ball;
  logic [1:0] s2_state;

  // stage 2 combinational
  logic        cell_ok, inner;
  logic [15:0] cell_idx;
  logic [1:0]  bstate;
  logic        flash_hit, pad_l, pad_r, ball;
  logic [11:0] adxl, adxr, adxb, adyb;

  logic [8:0]  rgb_next;

  function automatic logic [11:0] abs12(input logic signed [11:0] v);
    return v[11] ? 12'(-v) : 12'(v);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      xl_sh <= '0;
      xr_sh <= '0;
      xb_sh <= '0;
      yb_sh <= '0;
      armed <= 1'b0;
    end else if (frame_start) begin
      xl_sh <= x_paddle_l;
      xr_sh <= x_paddle_r;
      xb_sh <= x_ball;
      yb_sh <= y_ball;
      armed <= 1'b1;
    end
  end

  assign hit_in_range = {1'b0, hit_id} < N_IDS;

  // a valid hit takes precedence over the per-frame decrement
  always_ff @(posedge clk) begin
    if (!rst) begin
      flash_id  <= '0;
      flash_cnt <= '0;
    end else if (hit_valid && hit_in_range) begin
      flash_id  <= hit_id;
      flash_cnt <= FLASH_N;
    end else if (frame_start && flash_cnt != '0) begin
      flash_cnt <= flash_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_active <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s1_y      <= '0;
      s1_bx     <= '0;
      s1_ox     <= '0;
      s1_by     <= '0;
      s1_oy     <= '0;
      s1_dxl    <= '0;
      s1_dxr    <= '0;
      s1_dxb    <= '0;
      s1_dyb    <= '0;
    end else begin
      s1_active <= active;
      s1_hs     <= hs_in;
      s1_vs     <= vs_in;
      s1_y      <= y;
      s1_bx     <= x / BW_X;
      s1_ox     <= x % BW_X;
      s1_by     <= y / BH_Y;
      s1_oy     <= y % BH_Y;
      s1_dxl    <= $signed({1'b0, x}) - $signed({1'b0, xl_sh});
      s1_dxr    <= $signed({1'b0, x}) - $signed({1'b0, xr_sh});
      s1_dxb    <= $signed({1'b0, x}) - $signed({1'b0, xb_sh});
      s1_dyb    <= $signed({2'b00, y}) - $signed({2'b00, yb_sh});
    end
  end

  always_comb begin
    cell_ok  = (s1_bx < COLS_X) && (s1_by < ROWS_Y);
    inner    = cell_ok && (s1_y < FH_Y) &&
               (s1_ox >= GAP_X) && (s1_ox < XIN_HI) &&
               (s1_oy >= GAP_Y) && (s1_oy < YIN_HI);
    cell_idx = 16'(s1_by) * 16'(COLS) + 16'(s1_bx);

    // constant-index selection keeps out-of-field cells from indexing past the vector
    bstate = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (cell_ok && cell_idx == 16'(k))
        bstate = bricks[2*k +: 2];
    end

    flash_hit = inner && (flash_cnt != '0) && flash_cnt[0] &&
                (cell_idx == {8'b0, flash_id});

    adxl = abs12(s1_dxl);
    adxr = abs12(s1_dxr);
    adxb = abs12(s1_dxb);
    adyb = abs12(s1_dyb);

    pad_l = armed && (adxl <= PH) && (s1_y > PL0) && (s1_y <= PL1);
    pad_r = armed && (adxr <= PH) && (s1_y > PR0) && (s1_y <= PR1);
    ball  = armed && (adxb <= BR) && (adyb <= BR) &&
            (({1'b0, adxb} + {1'b0, adyb}) <= BSUM);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_active   <= 1'b0;
      s2_hs       <= 1'b0;
      s2_vs       <= 1'b0;
      s2_in_brick <= 1'b0;
      s2_state    <= '0;
      s2_flash    <= 1'b0;
      s2_pad_l    <= 1'b0;
      s2_pad_r    <= 1'b0;
      s2_ball     <= 1'b0;
    end else begin
      s2_active   <= s1_active;
      s2_hs       <= s1_hs;
      s2_vs       <= s1_vs;
      s2_in_brick <= inner;
      s2_state    <= bstate;
      s2_flash    <= flash_hit;
      s2_pad_l    <= pad_l;
      s2_pad_r    <= pad_r;
      s2_ball     <= ball;
    end
  end

  always_comb begin
    rgb_next = '0;
    if (s2_active) begin
      if (s2_ball)
        rgb_next = 9'h1FF;
      else if (s2_pad_r)
        rgb_next = 9'h1C0;
      else if (s2_pad_l)
        rgb_next = 9'h007;
      else if (s2_in_brick) begin
        if (s2_flash)
          rgb_next = 9'h1FF;
        else begin
          case (s2_state)
            2'd1:    rgb_next = 9'h1FF;
            2'd2:    rgb_next = 9'h1C0;
            2'd3:    rgb_next = 9'h03F;
            default: rgb_next = 9'h000;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rgb        <= '0;
      hs_out     <= 1'b0;
      vs_out     <= 1'b0;
      active_out <= 1'b0;
    end else begin
      rgb        <= rgb_next;
      hs_out     <= s2_hs;
      vs_out     <= s2_vs;
      active_out <= s2_active;
    end
  end

endmodule

// File: tb/tb_brick_render_pipe.sv
module tb_brick_render_pipe;

  logic         clk;
  logic         rst;
  logic [10:0]  x;
  logic [9:0]   y;
  logic         active;
  logic         hs_in, vs_in;
  logic         frame_start;
  logic [10:0]  x_paddle_l, x_paddle_r, x_ball;
  logic [9:0]   y_ball;
  logic [127:0] bricks;
  logic         hit_valid;
  logic [7:0]   hit_id;
  logic [8:0]   rgb;
  logic         hs_out, vs_out, active_out;

  int n_checks = 0;
  int n_errors = 0;

  brick_render_pipe #(
    .COLS(8),
    .ROWS(8),
    .FLASH_FRAMES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .x(x),
    .y(y),
    .active(active),
    .hs_in(hs_in),
    .vs_in(vs_in),
    .frame_start(frame_start),
    .x_paddle_l(x_paddle_l),
    .x_paddle_r(x_paddle_r),
    .x_ball(x_ball),
    .y_ball(y_ball),
    .bricks(bricks),
    .hit_valid(hit_valid),
    .hit_id(hit_id),
    .rgb(rgb),
    .hs_out(hs_out),
    .vs_out(vs_out),
    .active_out(active_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic probe(input int px, input int py, input logic [8:0] exp, input string tag);
    x = 11'(px);
    y = 10'(py);
    active = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val(tag, {7'b0, rgb}, {7'b0, exp});
  endtask

  task automatic frame_pulse();
    active = 1'b0;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic hit_pulse(input logic [7:0] id, input logic with_frame);
    active = 1'b0;
    hit_id = id;
    hit_valid = 1'b1;
    frame_start = with_frame;
    @(posedge clk);
    #1;
    hit_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  initial begin
    logic [8:0] exp_rgb;
    rst = 1'b0;
    x = '0; y = '0; active = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    frame_start = 1'b0; hit_valid = 1'b0; hit_id = '0;
    x_paddle_l = '0; x_paddle_r = '0; x_ball = '0; y_ball = '0;
    bricks = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_rgb", {7'b0, rgb}, 16'h0);
    check_val("reset_syncs", {13'b0, hs_out, vs_out, active_out}, 16'h0);
    rst = 1'b1;

    // before any frame_start: shadows at 0 but nothing armed
    probe(0, 0, 9'h000, "unarmed_ball");

    x_ball = 11'd400; y_ball = 10'd300;
    x_paddle_l = 11'd100; x_paddle_r = 11'd700;
    frame_pulse();

    // exact latency and sync alignment
    x = 11'd400; y = 10'd300; active = 1'b1; hs_in = 1'b1; vs_in = 1'b1;
    @(posedge clk); #1;
    x = 11'd0; y = 10'd450; hs_in = 1'b0; vs_in = 1'b0;
    @(posedge clk); #1;
    check_val("lat_cycle2", {7'b0, rgb}, 16'h0);
    check_val("lat_cycle2_hs", {15'b0, hs_out}, 16'h0);
    @(posedge clk); #1;
    check_val("lat_cycle3", {7'b0, rgb}, 16'h1FF);
    check_val("lat_syncs", {13'b0, hs_out, vs_out, active_out}, 16'h7);
    @(posedge clk); #1;
    check_val("lat_cycle4", {7'b0, rgb}, 16'h0);

    x = 11'd400; y = 10'd300; active = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_val("inactive_blank", {7'b0, rgb}, 16'h0);

    probe(404, 301, 9'h1FF, "ball_diag_in");
    probe(404, 302, 9'h000, "ball_diag_out");
    probe(396, 300, 9'h1FF, "ball_left_edge");
    probe(400, 305, 9'h000, "ball_below");
    probe(700, 575, 9'h1C0, "pad_r_center");
    probe(780, 575, 9'h1C0, "pad_r_edge");
    probe(781, 575, 9'h000, "pad_r_past");
    probe(100, 25, 9'h007, "pad_l_center");
    probe(100, 30, 9'h007, "pad_l_bottom");
    probe(100, 20, 9'h000, "pad_l_top_excl");

    bricks[19:18] = 2'd2;
    probe(105, 55, 9'h1C0, "brick9_corner");
    probe(104, 55, 9'h000, "brick9_gap_x");
    probe(194, 94, 9'h1C0, "brick9_far");
    probe(195, 55, 9'h000, "brick9_gap_hi");

    bricks = {64{2'b01}};
    probe(150, 380, 9'h1FF, "brick_row7");
    probe(150, 410, 9'h000, "brick_field_h");
    probe(850, 55, 9'h000, "brick_cols_lim");

    // priority: ball over brick, left paddle over brick
    bricks = '0;
    bricks[19:18] = 2'd2;
    bricks[3:2] = 2'd3;
    x_ball = 11'd150; y_ball = 10'd75; x_paddle_l = 11'd150;
    frame_pulse();
    probe(150, 75, 9'h1FF, "prio_ball");
    probe(150, 85, 9'h1C0, "prio_brick");
    probe(150, 25, 9'h007, "prio_pad_l");

    // no wrap near screen edge; frame-latched shadows
    x_ball = 11'd2; y_ball = 10'd2; x_paddle_l = 11'd100;
    frame_pulse();
    probe(0, 2, 9'h1FF, "ball_clip");
    probe(2045, 2, 9'h000, "ball_nowrap");
    x_ball = 11'd1000;
    probe(0, 2, 9'h1FF, "shadow_hold");

    // flash sequence on an empty cell
    bricks = '0;
    frame_pulse();
    hit_pulse(8'd9, 1'b0);
    probe(150, 75, 9'h000, "flash_cnt8");
    for (int f = 1; f <= 8; f++) begin
      frame_pulse();
      exp_rgb = ((8 - f) % 2 == 1) ? 9'h1FF : 9'h000;
      probe(150, 75, exp_rgb, $sformatf("flash_f%0d", f));
    end
    frame_pulse();
    probe(150, 75, 9'h000, "flash_done");

    // load beats decrement in the same cycle
    hit_pulse(8'd3, 1'b1);
    probe(350, 10, 9'h000, "flash_simul_8");
    frame_pulse();
    probe(350, 10, 9'h1FF, "flash_simul_7");
    hit_pulse(8'd200, 1'b0);
    probe(350, 10, 9'h1FF, "flash_oor_ignored");

    // mid-line reset
    bricks[19:18] = 2'd1;
    probe(150, 75, 9'h1FF, "pre_reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("rst_edge", {7'b0, rgb}, 16'h0);
    check_val("rst_active_out", {15'b0, active_out}, 16'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("rst_plus1", {7'b0, rgb}, 16'h0);
    @(posedge clk); #1;
    check_val("rst_plus2", {7'b0, rgb}, 16'h0);
    @(posedge clk); #1;
    check_val("rst_plus3", {7'b0, rgb}, 16'h1FF);
    probe(0, 0, 9'h000, "rst_disarm");
    probe(350, 10, 9'h000, "rst_flash_clear");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
